// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-to-AXI bridge: request type codes,
// AXI burst/size constants, FSM state encodings and the helpers that map a
// cache request type onto AXI burst length and beat size.
package cache_axi_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [7:0] LINE_LEN   = 8'd3;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_B}  wr_state_e;

  // Bit 2 of the request type marks a full-line (4-word) transfer.
  function automatic logic [7:0] axi_len(input logic [2:0] typ);
    return typ[2] ? LINE_LEN : 8'd0;
  endfunction

  function automatic logic [2:0] axi_size(input logic [2:0] typ);
    return typ[2] ? SIZE_4B : {1'b0, typ[1:0]};
  endfunction

endpackage

// File: rtl/axi_wr_buffer.sv
// One-entry write buffer with its write FSM and the AXI AW/W/B channels.
// Ports: cache write request (wr_*_i, wr_rdy_o), busy_o/line_addr_o for the
// read-after-write hazard compare in the parent, AXI AW/W/B master signals.
module axi_wr_buffer
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_req_i,
  input  logic [3:0]   wr_type_i,
  input  logic [31:0]  wr_addr_i,
  input  logic [3:0]   wr_wstrb_i,
  input  logic [127:0] wr_data_i,
  output logic         wr_rdy_o,
  output logic         busy_o,
  output logic [27:0]  line_addr_o,
  output logic [3:0]   awid_o,
  output logic [31:0]  awaddr_o,
  output logic [7:0]   awlen_o,
  output logic [2:0]   awsize_o,
  output logic [1:0]   awburst_o,
  output logic         awvalid_o,
  input  logic         awready_i,
  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb_o,
  output logic         wlast_o,
  output logic         wvalid_o,
  input  logic         wready_i,
  input  logic [3:0]   bid_i,
  input  logic [1:0]   bresp_i,
  input  logic         bvalid_i,
  output logic         bready_o
);

  wr_state_e      state_q;
  logic [31:0]    addr_q;
  logic [2:0]     type_q;
  logic [3:0]     wstrb_q;
  logic [127:0]   data_q;
  logic           aw_done_q;
  logic           w_done_q;
  logic [1:0]     beat_q;
  logic           aw_hs, w_hs, is_line;
  logic [1:0]     word_idx;
  logic           unused_wr;

  assign unused_wr = ^{bid_i, bresp_i, wr_type_i[3]};

  assign is_line   = type_q[2];
  assign awvalid_o = (state_q == W_SEND) & ~aw_done_q;
  // wvalid drops once the last beat is accepted so no extra W beat is sent
  // while AW is still waiting.
  assign wvalid_o  = (state_q == W_SEND) & ~w_done_q;
  assign aw_hs     = awvalid_o & awready_i;
  assign w_hs      = wvalid_o & wready_i;

  assign awid_o    = WR_ID;
  assign awaddr_o  = addr_q;
  assign awlen_o   = axi_len(type_q);
  assign awsize_o  = axi_size(type_q);
  assign awburst_o = BURST_INCR;

  // A single-beat write carries the word selected by its address; a line
  // write walks the buffer in beat order.
  assign word_idx  = is_line ? beat_q : addr_q[3:2];
  assign wdata_o   = data_q[{word_idx, 5'd0} +: 32];
  assign wstrb_o   = is_line ? 4'hf : wstrb_q;
  assign wlast_o   = (beat_q == awlen_o[1:0]);

  assign bready_o    = (state_q == W_B);
  assign wr_rdy_o    = (state_q == W_IDLE);
  assign busy_o      = ~wr_rdy_o;
  assign line_addr_o = addr_q[31:4];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      type_q    <= '0;
      wstrb_q   <= '0;
      data_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      beat_q    <= '0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (wr_req_i) begin
            addr_q    <= wr_addr_i;
            type_q    <= wr_type_i[2:0];
            wstrb_q   <= wr_wstrb_i;
            data_q    <= wr_data_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            beat_q    <= '0;
            state_q   <= W_SEND;
          end
        end
        W_SEND: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs) begin
            beat_q <= beat_q + 2'd1;
            if (wlast_o) w_done_q <= 1'b1;
          end
          // AW and the last W beat may complete in either order or together.
          if ((aw_done_q | aw_hs) & (w_done_q | (w_hs & wlast_o)))
            state_q <= W_B;
        end
        W_B: begin
          if (bvalid_i) state_q <= W_IDLE;
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Memory-side responder for a cache refill/write-back port. Reads become
// AXI AR/R transactions (one outstanding) and refill data is passed back on
// ret_*; writes go through a one-entry buffer (axi_wr_buffer) to AW/W/B.
// Ports: cache rd_*/ret_*/wr_* interface, AXI4 master AR/R/AW/W/B channels.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [3:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [1:0]   ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [3:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_e   rd_state_q;
  logic [31:0] rd_addr_q;
  logic [2:0]  rd_type_q;
  logic        arvalid_q;
  logic        wb_busy;
  logic [27:0] wb_line;
  logic        hazard;
  logic        unused_rd;

  assign unused_rd = ^{rid, rresp, rd_type[3]};

  // Block reads of a line that is buffered, or is being buffered this cycle,
  // until its B response has come back.
  assign hazard = (wb_busy & (rd_addr[31:4] == wb_line)) |
                  (wr_req & wr_rdy & (rd_addr[31:4] == wr_addr[31:4]));
  assign rd_rdy = (rd_state_q == R_IDLE) & ~hazard;

  assign arid    = RD_ID;
  assign araddr  = rd_addr_q;
  assign arlen   = axi_len(rd_type_q);
  assign arsize  = axi_size(rd_type_q);
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_q;

  assign rready    = (rd_state_q == R_DATA);
  assign ret_valid = rready & rvalid;
  assign ret_data  = rdata;
  assign ret_last  = {1'b0, rready & rlast};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_type_q  <= '0;
      arvalid_q  <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            rd_addr_q  <= rd_addr;
            rd_type_q  <= rd_type[2:0];
            arvalid_q  <= 1'b1;
            rd_state_q <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q  <= 1'b0;
            rd_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rlast) rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  axi_wr_buffer #(.WR_ID(WR_ID)) u_wr_buffer (
    .clk        (clk),
    .resetn     (resetn),
    .wr_req_i   (wr_req),
    .wr_type_i  (wr_type),
    .wr_addr_i  (wr_addr),
    .wr_wstrb_i (wr_wstrb),
    .wr_data_i  (wr_data),
    .wr_rdy_o   (wr_rdy),
    .busy_o     (wb_busy),
    .line_addr_o(wb_line),
    .awid_o     (awid),
    .awaddr_o   (awaddr),
    .awlen_o    (awlen),
    .awsize_o   (awsize),
    .awburst_o  (awburst),
    .awvalid_o  (awvalid),
    .awready_i  (awready),
    .wdata_o    (wdata),
    .wstrb_o    (wstrb),
    .wlast_o    (wlast),
    .wvalid_o   (wvalid),
    .wready_i   (wready),
    .bid_i      (bid),
    .bresp_i    (bresp),
    .bvalid_i   (bvalid),
    .bready_o   (bready)
  );

endmodule
